// File: rtl/vga_scanout.sv
// VGA raster scanout: free-running h/v counters gated by a pixel tick, feeding a
// two-stage pipeline (address/flags, then pixel/sync outputs) against a combinational frame memory.
module vga_scanout #(
    parameter int   WordSize    = 8,
    parameter int   Rows_Bus    = 10,
    parameter int   Columns_Bus = 10,
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pix_en,
    output logic [Rows_Bus-1:0]    o_raddr_row,
    output logic [Columns_Bus-1:0] o_raddr_col,
    input  logic [WordSize-1:0]    i_rdata,
    output logic [WordSize-1:0]    o_pixel,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic                   o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    // Region bounds kept as 32-bit constants so an empty back porch cannot overflow the counter width.
    localparam int unsigned H_VIS_END  = H_VISIBLE;
    localparam int unsigned HS_START   = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned H_LAST     = H_TOTAL - 1;
    localparam int unsigned V_VIS_END  = V_VISIBLE;
    localparam int unsigned VS_START   = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END     = V_VISIBLE + V_FRONT + V_SYNC;
    localparam int unsigned V_LAST     = V_TOTAL - 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic h_last;
    logic v_last;
    logic visible;
    logic hs_on;
    logic vs_on;
    logic at_origin;

    logic vis_s1;
    logic hs_s1;
    logic vs_s1;
    logic fs_s1;

    always_comb begin
        h_last    = 32'(h_cnt) == H_LAST;
        v_last    = 32'(v_cnt) == V_LAST;
        visible   = (32'(h_cnt) < H_VIS_END) && (32'(v_cnt) < V_VIS_END);
        hs_on     = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
        vs_on     = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Stage 1: memory address plus position flags for the same pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_raddr_row <= '0;
            o_raddr_col <= '0;
            vis_s1      <= 1'b0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            fs_s1       <= 1'b0;
        end else if (i_pix_en) begin
            o_raddr_row <= visible ? Rows_Bus'(v_cnt) : '0;
            o_raddr_col <= visible ? Columns_Bus'(h_cnt) : '0;
            vis_s1      <= visible;
            hs_s1       <= hs_on;
            vs_s1       <= vs_on;
            fs_s1       <= at_origin;
        end
    end

    // Stage 2: i_rdata answers the stage-1 address, so pixel and flags stay aligned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel       <= '0;
            o_de          <= 1'b0;
            o_hsync       <= ~SYNC_ACTIVE;
            o_vsync       <= ~SYNC_ACTIVE;
            o_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            o_pixel       <= vis_s1 ? i_rdata : '0;
            o_de          <= vis_s1;
            o_hsync       <= hs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            o_vsync       <= vs_s1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            o_frame_start <= fs_s1;
        end
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter WordSize, 8, width of one pixel word read from the frame memory.
REQ-002 Parameters Rows_Bus, 10 and Columns_Bus, 10: frame memory row and column address widths.
REQ-003 Parameters H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal timing in pixel ticks.
REQ-004 Parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical timing in lines.
REQ-005 Parameter SYNC_ACTIVE, 0, level of o_hsync/o_vsync during the sync pulse.
REQ-006 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-007 i_rst  input  1  synchronous, active-high reset.
REQ-008 i_pix_en  input  1  pixel tick; state advances only on cycles where it is 1.
REQ-009 o_raddr_row  output  Rows_Bus  frame memory read row address.
REQ-010 o_raddr_col  output  Columns_Bus  frame memory read column address.
REQ-011 i_rdata  input  WordSize  read data, combinational function of o_raddr_row/o_raddr_col (same cycle).
REQ-012 o_pixel  output  WordSize  pixel value; 0 outside the visible area.
REQ-013 o_hsync, o_vsync  output  1 each  sync pulses at SYNC_ACTIVE level.
REQ-014 o_de  output  1  1 while o_pixel carries a visible pixel.
REQ-015 o_frame_start  output  1  one-tick pulse coincident with visible pixel (0,0) on o_pixel.

Function
REQ-016 Internal h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params), v_cnt 0..V_TOTAL-1; both advance only when i_pix_en=1.
REQ-017 h_cnt = H_TOTAL-1 with i_pix_en -> h_cnt 0 and v_cnt+1; both at terminal value -> both 0 (frame wrap).
REQ-018 Region order per axis: visible, front porch, sync, back porch; visible = h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-019 Stage 1 (on tick): o_raddr_col <= h_cnt, o_raddr_row <= v_cnt when visible, else both <= 0; visible/sync/frame-start flags registered alongside.
REQ-020 Stage 2 (on tick): o_pixel <= i_rdata when stage-1 visible flag set, else 0; o_de, o_hsync, o_vsync, o_frame_start registered from stage-1 flags.
REQ-021 Latency: counter position to o_pixel/o_de/syncs = exactly 2 enabled ticks; all outputs mutually aligned.
REQ-022 hsync active for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; vsync likewise on v_cnt, held for whole lines.
REQ-023 o_frame_start is 1 for exactly one enabled tick per frame; it is cleared on the next enabled tick.
REQ-024 i_pix_en=0: counters, pipeline and all outputs hold their values (o_frame_start holds too).
REQ-025 Counters are wide enough for H_TOTAL-1/V_TOTAL-1; H_VISIBLE <= 2**Columns_Bus and V_VISIBLE <= 2**Rows_Bus are required parameter constraints.

Reset
REQ-026 i_rst=1 on a clock edge overrides i_pix_en: h_cnt, v_cnt, both pipeline stages <= 0/inactive.
REQ-027 Reset values: o_raddr_row=0, o_raddr_col=0, o_pixel=0, o_de=0, o_frame_start=0, o_hsync=o_vsync=~SYNC_ACTIVE.
REQ-028 Reset mid-frame discards in-flight pipeline data; first enabled tick after release processes counter (0,0).

Verification
Bench params: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), memory model returns {row[3:0],col[3:0]}, i_pix_en=1.
REQ-029 Release reset -> o_frame_start=1 and o_de=1, o_pixel=0x00 on 2nd tick after release; o_pixel 0x01,0x02,0x03 follow.
REQ-030 Full frame -> o_de high 12 ticks of 48; o_hsync active 2 ticks per line at columns 5..6; o_vsync active for line 4 (8 ticks).
REQ-031 Line wrap -> row-1 pixels 0x10..0x13 appear 8 ticks after 0x00..0x03; o_pixel=0 during blanking.
REQ-032 Frame wrap -> o_frame_start re-asserts exactly 48 ticks after previous pulse, never elsewhere.
REQ-033 i_pix_en toggled 1,0,0,1 pattern -> output sequence identical to continuous run with ticks removed; outputs hold while 0.
REQ-034 Assert i_rst at h_cnt=2, v_cnt=1 -> next cycle all outputs at reset values; restart repeats REQ-029 exactly.
